// File: rtl/csr_enc_hls_deadlock_reporter.sv
// Watches the OR of per-instance deadlock monitor block flags and declares a sticky deadlock
// after THRESHOLD consecutive blocked cycles, then offers a one-shot ready/valid report record.
module csr_enc_hls_deadlock_reporter #(
  parameter int unsigned NUM_MON   = 4,
  parameter int unsigned THRESHOLD = 16,
  parameter int unsigned TS_W      = 32
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NUM_MON-1:0] mon_block,
  input  logic               clear,
  output logic               deadlock,
  output logic               report_valid,
  input  logic               report_ready,
  output logic [NUM_MON-1:0] report_mask,
  output logic [TS_W-1:0]    report_time,
  output logic [7:0]         report_count
);

  typedef enum logic [1:0] {StIdle, StWatch, StReport, StLatched} state_e;

  localparam logic [15:0] RunLast = 16'(THRESHOLD - 1);

  state_e             state_q, state_d;
  logic [15:0]        run_q, run_d;
  logic [TS_W-1:0]    ts_q;
  logic               deadlock_q, deadlock_d;
  logic [NUM_MON-1:0] mask_q, mask_d;
  logic [TS_W-1:0]    time_q, time_d;
  logic [7:0]         count_q, count_d;
  logic               any_blk;

  assign any_blk = |mon_block;

  always_comb begin
    state_d    = state_q;
    run_d      = run_q;
    deadlock_d = deadlock_q;
    mask_d     = mask_q;
    time_d     = time_q;
    count_d    = count_q;
    if (clear) begin
      // Re-arm wins over any declaration or handshake landing on the same edge.
      state_d    = StIdle;
      run_d      = '0;
      deadlock_d = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (any_blk) begin
            state_d = StWatch;
            run_d   = 16'd1;
          end else begin
            run_d = '0;
          end
        end
        StWatch: begin
          if (!any_blk) begin
            state_d = StIdle;
            run_d   = '0;
          end else if (run_q == RunLast) begin
            state_d    = StReport;
            run_d      = '0;
            deadlock_d = 1'b1;
            mask_d     = mon_block;
            time_d     = ts_q;
          end else begin
            run_d = run_q + 16'd1;
          end
        end
        StReport: begin
          run_d = '0;
          if (report_ready) begin
            state_d = StLatched;
            if (count_q != 8'hFF) count_d = count_q + 8'd1;
          end
        end
        StLatched: begin
          run_d = '0;
        end
        default: begin
          state_d = StIdle;
          run_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= StIdle;
      run_q      <= '0;
      ts_q       <= '0;
      deadlock_q <= 1'b0;
      mask_q     <= '0;
      time_q     <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      run_q      <= run_d;
      deadlock_q <= deadlock_d;
      mask_q     <= mask_d;
      time_q     <= time_d;
      count_q    <= count_d;
      if (ts_q != {TS_W{1'b1}}) ts_q <= ts_q + 1'b1;
    end
  end

  assign deadlock     = deadlock_q;
  assign report_valid = (state_q == StReport);
  assign report_mask  = mask_q;
  assign report_time  = time_q;
  assign report_count = count_q;

endmodule

// File: tb/tb_csr_enc_hls_deadlock_reporter.sv
// Random plus directed stimulus for the deadlock reporter, checked every cycle against a
// streak-counting behavioural model, with literal expectations for the key scenarios.
module tb_csr_enc_hls_deadlock_reporter;

  localparam int unsigned NUM_MON   = 4;
  localparam int unsigned THRESHOLD = 16;
  localparam int unsigned TS_W      = 32;

  logic               clock;
  logic               reset;
  logic [NUM_MON-1:0] mon_block;
  logic               clear;
  logic               deadlock;
  logic               report_valid;
  logic               report_ready;
  logic [NUM_MON-1:0] report_mask;
  logic [TS_W-1:0]    report_time;
  logic [7:0]         report_count;

  csr_enc_hls_deadlock_reporter #(
    .NUM_MON  (NUM_MON),
    .THRESHOLD(THRESHOLD),
    .TS_W     (TS_W)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .mon_block   (mon_block),
    .clear       (clear),
    .deadlock    (deadlock),
    .report_valid(report_valid),
    .report_ready(report_ready),
    .report_mask (report_mask),
    .report_time (report_time),
    .report_count(report_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a streak of blocked edges, a sticky flag and a pending-report bit.
  int                 streak;
  bit                 m_dl, m_pend, model_ok;
  logic [NUM_MON-1:0] m_mask;
  logic [TS_W-1:0]    m_ts, m_time, ts_now;
  int                 m_cnt;

  initial model_ok = 1'b0;

  always @(posedge clock) begin
    if (reset) begin
      streak = 0; m_dl = 0; m_pend = 0; m_mask = '0; m_ts = '0; m_time = '0; m_cnt = 0;
      model_ok = 1'b1;
    end else if (model_ok) begin
      ts_now = m_ts;
      if (m_ts != {TS_W{1'b1}}) m_ts = m_ts + 1;
      if (clear) begin
        m_dl = 0; m_pend = 0; streak = 0;
      end else if (!m_dl) begin
        if (mon_block != '0) begin
          streak++;
          if (streak == THRESHOLD) begin
            m_dl = 1; m_pend = 1; m_mask = mon_block; m_time = ts_now; streak = 0;
          end
        end else begin
          streak = 0;
        end
      end else if (m_pend && report_ready) begin
        m_pend = 0;
        if (m_cnt < 255) m_cnt++;
      end
    end
  end

  always @(negedge clock) begin
    if (model_ok) begin
      chk("cyc_deadlock", 64'(deadlock), 64'(m_dl));
      chk("cyc_valid", 64'(report_valid), 64'(m_pend));
      chk("cyc_mask", 64'(report_mask), 64'(m_mask));
      chk("cyc_time", 64'(report_time), 64'(m_time));
      chk("cyc_count", 64'(report_count), 64'(m_cnt));
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  bit blk_phase;

  initial begin
    reset = 1'b1; clear = 1'b0; report_ready = 1'b0; mon_block = '0;
    step(3);
    chk("rst_deadlock", 64'(deadlock), 64'd0);
    chk("rst_valid", 64'(report_valid), 64'd0);
    chk("rst_mask", 64'(report_mask), 64'd0);
    chk("rst_time", 64'(report_time), 64'd0);
    chk("rst_count", 64'(report_count), 64'd0);
    reset = 1'b0;

    // First blocked edge samples timestamp 10, the 16th samples 25.
    step(10);
    mon_block = 4'b0100;
    step(15);
    chk("thr_minus1_deadlock", 64'(deadlock), 64'd0);
    step(1);
    chk("thr_deadlock", 64'(deadlock), 64'd1);
    chk("thr_valid", 64'(report_valid), 64'd1);
    chk("thr_mask", 64'(report_mask), 64'h4);
    chk("thr_time", 64'(report_time), 64'd25);

    for (int i = 0; i < 20; i++) begin
      mon_block = 4'($urandom_range(0, 15));
      step(1);
      chk("hold_valid", 64'(report_valid), 64'd1);
      chk("hold_mask", 64'(report_mask), 64'h4);
      chk("hold_time", 64'(report_time), 64'd25);
    end
    report_ready = 1'b1;
    step(1);
    report_ready = 1'b0;
    chk("hs1_count", 64'(report_count), 64'd1);
    chk("hs1_valid", 64'(report_valid), 64'd0);
    chk("hs1_deadlock", 64'(deadlock), 64'd1);

    // Re-arm from the latched state.
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    mon_block = 4'b1000;
    chk("clr_deadlock", 64'(deadlock), 64'd0);
    step(15);
    chk("rearm_early", 64'(deadlock), 64'd0);
    step(1);
    chk("rearm_deadlock", 64'(deadlock), 64'd1);
    chk("rearm_mask", 64'(report_mask), 64'h8);
    report_ready = 1'b1;
    step(1);
    report_ready = 1'b0;
    chk("hs2_count", 64'(report_count), 64'd2);

    // Clear racing a handshake.
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    mon_block = 4'b0011;
    step(16);
    chk("race_valid_pre", 64'(report_valid), 64'd1);
    report_ready = 1'b1;
    clear = 1'b1;
    step(1);
    report_ready = 1'b0;
    clear = 1'b0;
    mon_block = '0;
    chk("race_deadlock", 64'(deadlock), 64'd0);
    chk("race_valid", 64'(report_valid), 64'd0);
    chk("race_count", 64'(report_count), 64'd2);

    // One unblocked cycle restarts the window.
    step(1);
    mon_block = 4'b0010;
    step(15);
    mon_block = '0;
    step(1);
    mon_block = 4'b0010;
    step(15);
    chk("gap_deadlock", 64'(deadlock), 64'd0);
    mon_block = '0;
    step(1);

    // Random traffic, checked by the per-cycle compare.
    blk_phase = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 19) == 0) blk_phase = ~blk_phase;
      if (blk_phase) mon_block = 4'($urandom_range(1, 15));
      else if ($urandom_range(0, 29) == 0) mon_block = 4'($urandom_range(0, 15));
      else mon_block = '0;
      report_ready = ($urandom_range(0, 3) == 0);
      clear = ($urandom_range(0, 99) == 0);
      reset = ($urandom_range(0, 499) == 0);
      step(1);
    end
    reset = 1'b0; clear = 1'b0; report_ready = 1'b0; mon_block = '0;

    // Reset while a report waits for ready.
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    mon_block = 4'b0001;
    step(16);
    chk("rpt_valid_pre", 64'(report_valid), 64'd1);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    chk("rst2_deadlock", 64'(deadlock), 64'd0);
    chk("rst2_valid", 64'(report_valid), 64'd0);
    chk("rst2_mask", 64'(report_mask), 64'd0);
    chk("rst2_time", 64'(report_time), 64'd0);
    chk("rst2_count", 64'(report_count), 64'd0);

    // 300 report cycles to saturate the accepted-report counter.
    for (int i = 0; i < 300; i++) begin
      clear = 1'b1;
      step(1);
      clear = 1'b0;
      mon_block = 4'b0001;
      report_ready = 1'b1;
      step(17);
      report_ready = 1'b0;
      if (i == 9) chk("sat_count_10", 64'(report_count), 64'd10);
    end
    chk("sat_count", 64'(report_count), 64'd255);
    chk("sat_deadlock", 64'(deadlock), 64'd1);

    step(2);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/csr_enc_hls_deadlock_reporter.md
CSR_ENC_HLS_DEADLOCK_REPORTER -- requirements
Module: csr_enc_hls_deadlock_reporter

Interface
REQ-001 Parameter NUM_MON, default 4, meaning number of per-instance deadlock monitor block outputs consumed.
REQ-002 Parameter THRESHOLD, default 16, meaning consecutive blocked cycles before a deadlock is declared; legal range 2..65535.
REQ-003 Parameter TS_W, default 32, meaning width of the cycle timestamp.
REQ-004 clock  input  1  single clock; all logic on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 mon_block  input  NUM_MON  block outputs of the per-instance idx monitors; bit i = monitor i reports blocked.
REQ-007 clear  input  1  single-cycle re-arm request.
REQ-008 deadlock  output  1  sticky deadlock-declared flag.
REQ-009 report_valid  output  1  report record available.
REQ-010 report_ready  input  1  consumer accepts the record.
REQ-011 report_mask  output  NUM_MON  mon_block snapshot at declaration.
REQ-012 report_time  output  TS_W  timestamp at declaration.
REQ-013 report_count  output  8  number of accepted reports since reset, saturating at 255.

Function
REQ-014 any_blk SHALL be the OR of all mon_block bits, sampled each rising edge.
REQ-015 A free-running timestamp SHALL increment by 1 every cycle from 0 after reset and saturate at all-ones.
REQ-016 FSM states SHALL be IDLE, WATCH, REPORT, LATCHED.
REQ-017 A 16-bit run counter (run) SHALL count consecutive edges with any_blk=1.
REQ-018 IDLE: any_blk=1 -> WATCH with run=1; else stay with run=0.
REQ-019 WATCH: any_blk=0 -> IDLE with run=0.
REQ-020 WATCH: any_blk=1 and run<THRESHOLD-1 -> run+1, stay.
REQ-021 WATCH: any_blk=1 and run=THRESHOLD-1 -> REPORT; at the same edge, deadlock<=1, report_mask<=mon_block, report_time<=current timestamp.
REQ-022 The THRESHOLD-th consecutive blocked edge SHALL be the edge that asserts deadlock; a single unblocked cycle anywhere in the window SHALL restart counting.
REQ-023 REPORT: report_valid=1 and report_mask/report_time SHALL be held stable until report_valid&&report_ready.
REQ-024 REPORT: on handshake -> LATCHED, report_count+1 (saturating); report_valid is 0 from the next cycle.
REQ-025 report_ready while report_valid=0 SHALL have no effect.
REQ-026 LATCHED: deadlock stays 1; mon_block is ignored; run is held at 0.
REQ-027 clear=1 SHALL have priority in every state: next state IDLE, deadlock<=0, run<=0, report_valid<=0; report_mask, report_time, and report_count are retained.
REQ-028 clear coincident with a REPORT handshake: clear wins, and report_count SHALL NOT increment.
REQ-029 clear coincident with a declaring edge (REQ-021) SHALL prevent the declaration.
REQ-030 mon_block changes while in REPORT SHALL NOT alter the held report_mask.

Reset
REQ-031 On reset: state IDLE, run=0, timestamp=0, deadlock=0, report_valid=0, report_mask=0, report_time=0, report_count=0.
REQ-032 Reset SHALL override clear and every in-progress transition, including REPORT awaiting ready.

Verification
REQ-033 THRESHOLD=16; mon_block=4'b0100 held from cycle 10 -> deadlock rises after the 16th sampling edge; report_mask=4'b0100; report_time=timestamp at that edge.
REQ-034 mon_block=4'b0010 for 15 cycles, 0 for 1 cycle, 4'b0010 again for 15 cycles -> deadlock never asserts.
REQ-035 REPORT with report_ready low for 20 cycles while mon_block toggles -> report_valid stays 1; report_mask/report_time stay stable; handshake then gives report_count=1 and LATCHED.
REQ-036 In LATCHED, pulse clear, then hold mon_block=4'b1000 -> deadlock drops the cycle after clear and re-asserts after 16 edges; report_count=2 after the second handshake.
REQ-037 clear in the same cycle as the REPORT handshake -> IDLE, report_count unchanged, deadlock=0.
REQ-038 reset asserted in REPORT -> all outputs 0 the next cycle; 300 simulated handshakes -> report_count saturates at 255.
